gtx_prbs_tx_c160: RTL and testbench

- Transmit-side PRBS source for the 48-bit GTX link test.
- Produces the frame stream the receive-side PRBS checker locks to:
  - idle frames;
  - then a burst of the 48-bit start pattern;
  - then continuous frames built from a 24-bit [24,23,22,17] Fibonacci LFSR.
- Runs in the 160 MHz domain. Frames advance on the CE3 phase strobe; the LFSR also steps on CE1, giving two 24-bit words per frame.
- Supports single-bit error injection for checker verification.

---
 rtl/gtx_prbs_tx_c160.sv | 175 +++++++++++++++++
 tb/tb_gtx_prbs_tx_c160.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtx_prbs_tx_c160.sv
// Transmit-side PRBS frame source for the 48-bit GTX link test: idle, start burst, then LFSR frames.
// Optional FRM_CNT frame counter is built only when PRBS_TX_FRAME_CNT_EN is defined.
module gtx_prbs_tx_c160 #(
  parameter logic [47:0] StartPattern = 48'hFFFFFF000000,
  parameter logic [47:0] IdlePattern  = 48'h000000000000,
  parameter logic [23:0] InitFill     = 24'h83B62E,
  parameter int unsigned StartFrames  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ce1_i,
  input  logic        ce3_i,
  input  logic        ena_i,
  input  logic        start_i,
  input  logic        inj_err_i,
  output logic [47:0] tx_data_o,
  output logic        tx_strt_o,
  output logic        tx_prbs_o,
  output logic [7:0]  inj_cnt_o,
  output logic [31:0] frm_cnt_o
);

  typedef enum logic [1:0] {StIdle, StStrt, StPrbs} state_e;

  function automatic logic [23:0] lfsr_step(input logic [23:0] l);
    return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [23:0] lfsr_q, lfsr_d;
  logic [23:0] hi_q, hi_d;
  logic [47:0] tx_data_q, tx_data_d;
  logic        tx_strt_q, tx_strt_d;
  logic        tx_prbs_q, tx_prbs_d;
  logic        start_req_q, start_req_d;
  logic        inj_req_q, inj_req_d;
  logic [7:0]  inj_cnt_q, inj_cnt_d;
  logic [47:0] frame;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    hi_d        = hi_q;
    tx_data_d   = tx_data_q;
    tx_strt_d   = tx_strt_q;
    tx_prbs_d   = tx_prbs_q;
    start_req_d = start_req_q | start_i;
    inj_req_d   = inj_req_q | inj_err_i;
    inj_cnt_d   = inj_cnt_q;
    frame       = '0;

    if (state_q != StPrbs) begin
      lfsr_d = InitFill;
    end else if (ce1_i) begin
      // CE1 captures the upper word of the frame that the following CE3 emits
      hi_d   = lfsr_q;
      lfsr_d = lfsr_step(lfsr_q);
    end

    if (ce3_i) begin
      if (!ena_i) begin
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_req_q) begin
              state_d = StStrt;
              cnt_d   = 8'(StartFrames);
            end
          end
          StStrt: begin
            if (cnt_q == 8'd1) state_d = StPrbs;
            else               cnt_d   = cnt_q - 8'd1;
          end
          StPrbs: begin
            if (start_req_q) begin
              state_d = StStrt;
              cnt_d   = 8'(StartFrames);
            end
          end
          default: state_d = StIdle;
        endcase
      end

      unique case (state_d)
        StStrt: begin
          tx_data_d = StartPattern;
          tx_strt_d = 1'b1;
          tx_prbs_d = 1'b0;
          lfsr_d    = InitFill;
          if (state_q != StStrt) start_req_d = start_i;
        end
        StPrbs: begin
          // First frame of a run comes straight from the init fill; later ones from hi/lfsr
          if (state_q == StPrbs) begin
            frame  = {hi_q, lfsr_q};
            lfsr_d = lfsr_step(lfsr_q);
          end else begin
            frame  = {InitFill, lfsr_step(InitFill)};
            lfsr_d = lfsr_step(lfsr_step(InitFill));
          end
          tx_data_d = frame ^ {47'b0, inj_req_q};
          tx_strt_d = 1'b0;
          tx_prbs_d = 1'b1;
          inj_req_d = inj_err_i;
          if (inj_req_q && inj_cnt_q != 8'hFF) inj_cnt_d = inj_cnt_q + 8'd1;
        end
        default: begin
          tx_data_d = IdlePattern;
          tx_strt_d = 1'b0;
          tx_prbs_d = 1'b0;
          lfsr_d    = InitFill;
        end
      endcase
    end

    if (!ena_i) start_req_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      lfsr_q      <= InitFill;
      hi_q        <= '0;
      tx_data_q   <= IdlePattern;
      tx_strt_q   <= 1'b0;
      tx_prbs_q   <= 1'b0;
      start_req_q <= 1'b0;
      inj_req_q   <= 1'b0;
      inj_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      hi_q        <= hi_d;
      tx_data_q   <= tx_data_d;
      tx_strt_q   <= tx_strt_d;
      tx_prbs_q   <= tx_prbs_d;
      start_req_q <= start_req_d;
      inj_req_q   <= inj_req_d;
      inj_cnt_q   <= inj_cnt_d;
    end
  end

`ifdef PRBS_TX_FRAME_CNT_EN
  logic [31:0] frm_cnt_q, frm_cnt_d;

  always_comb begin
    frm_cnt_d = frm_cnt_q;
    if (ce3_i && state_d == StStrt && state_q != StStrt) begin
      frm_cnt_d = '0;
    end else if (ce3_i && state_d == StPrbs) begin
      frm_cnt_d = frm_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) frm_cnt_q <= '0;
    else       frm_cnt_q <= frm_cnt_d;
  end

  assign frm_cnt_o = frm_cnt_q;
`else
  assign frm_cnt_o = '0;
`endif

  assign tx_data_o = tx_data_q;
  assign tx_strt_o = tx_strt_q;
  assign tx_prbs_o = tx_prbs_q;
  assign inj_cnt_o = inj_cnt_q;

endmodule

// File: tb/tb_gtx_prbs_tx_c160.sv
// Directed bench for gtx_prbs_tx_c160: start burst, PRBS frames, injection, ENA drop, reset.
module tb_gtx_prbs_tx_c160;

  localparam logic [47:0] StartPat = 48'hFFFFFF000000;
  localparam logic [47:0] Frame0   = 48'h83B62E076C5C;
  localparam logic [47:0] Frame1   = 48'h0ED8B91DB172;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        start = 1'b0;
  logic        inj = 1'b0;
  logic [1:0]  ph = 2'd0;
  logic        ce1, ce3;
  logic [47:0] tx_data;
  logic        tx_strt, tx_prbs;
  logic [7:0]  inj_cnt;
  logic [31:0] frm_cnt;

  int checks = 0;
  int failures = 0;

  gtx_prbs_tx_c160 dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ce1_i    (ce1),
    .ce3_i    (ce3),
    .ena_i    (ena),
    .start_i  (start),
    .inj_err_i(inj),
    .tx_data_o(tx_data),
    .tx_strt_o(tx_strt),
    .tx_prbs_o(tx_prbs),
    .inj_cnt_o(inj_cnt),
    .frm_cnt_o(frm_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign ce1 = (ph == 2'd1);
  assign ce3 = (ph == 2'd3);

  // Reference frame k built word by word from the polynomial
  function automatic logic [47:0] model_frame(input int k);
    logic [23:0] l;
    logic [23:0] hi;
    l = 24'h83B62E;
    for (int i = 0; i < 2 * k; i++) l = {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
    hi = l;
    l = {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
    return {hi, l};
  endfunction

  // Advance past the next CE3 edge; called at edge+1 where ce3 is stable
  task automatic step_ce3();
    bit hit;
    hit = 1'b0;
    while (!hit) begin
      hit = ce3;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic pulse(input bit s, input bit e);
    start = s;
    inj = e;
    @(posedge clk);
    #1;
    start = 1'b0;
    inj = 1'b0;
  endtask

  task automatic expect_start_frames(input string tag);
    for (int i = 0; i < 4; i++) begin
      step_ce3();
      checks++;
      if (tx_data !== StartPat || tx_strt !== 1'b1 || tx_prbs !== 1'b0) begin
        failures++;
        $display("FAIL %s start%0d: got data=%h strt=%b prbs=%b, want data=%h strt=1 prbs=0",
                 tag, i, tx_data, tx_strt, tx_prbs, StartPat);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (tx_data !== 48'h0 || tx_strt !== 1'b0 || tx_prbs !== 1'b0 || inj_cnt !== 8'h0 ||
        frm_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset: got data=%h strt=%b prbs=%b inj=%h frm=%h, want all zero",
               tx_data, tx_strt, tx_prbs, inj_cnt, frm_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    ena = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step_ce3();
      checks++;
      if (tx_data !== 48'h0 || tx_strt !== 1'b0 || tx_prbs !== 1'b0) begin
        failures++;
        $display("FAIL idle%0d: got data=%h strt=%b prbs=%b, want 0/0/0",
                 i, tx_data, tx_strt, tx_prbs);
      end
    end
  endtask

  task automatic test_start_burst();
    pulse(1'b1, 1'b0);
    expect_start_frames("burst");
    for (int k = 0; k <= 50; k++) begin
      logic [47:0] exp_d;
      step_ce3();
      exp_d = model_frame(k);
      if (k == 0) exp_d = Frame0;
      if (k == 1) exp_d = Frame1;
      if (k == 10) exp_d = exp_d ^ 48'h1;
      checks++;
      if (tx_data !== exp_d || tx_prbs !== 1'b1 || tx_strt !== 1'b0) begin
        failures++;
        $display("FAIL prbs frame%0d: got data=%h prbs=%b strt=%b, want data=%h prbs=1 strt=0",
                 k, tx_data, tx_prbs, tx_strt, exp_d);
      end
      if (k == 9) pulse(1'b0, 1'b1);
      if (k == 10) begin
        checks++;
        if (inj_cnt !== 8'd1) begin
          failures++;
          $display("FAIL inj_cnt after frame10: got %0d want 1", inj_cnt);
        end
      end
    end
    checks++;
`ifdef PRBS_TX_FRAME_CNT_EN
    if (frm_cnt !== 32'd51) begin
      failures++;
      $display("FAIL frm_cnt at frame50: got %0d want 51", frm_cnt);
    end
`else
    if (frm_cnt !== 32'd0) begin
      failures++;
      $display("FAIL frm_cnt tied: got %0d want 0", frm_cnt);
    end
`endif
    pulse(1'b1, 1'b0);
    expect_start_frames("restart");
    checks++;
    if (frm_cnt !== 32'd0) begin
      failures++;
      $display("FAIL frm_cnt in restart burst: got %0d want 0", frm_cnt);
    end
    step_ce3();
    checks++;
    if (tx_data !== Frame0) begin
      failures++;
      $display("FAIL restart frame0: got %h want %h", tx_data, Frame0);
    end
    step_ce3();
    checks++;
    if (tx_data !== Frame1) begin
      failures++;
      $display("FAIL restart frame1: got %h want %h", tx_data, Frame1);
    end
  endtask

  task automatic test_ena_drop();
    pulse(1'b1, 1'b0);
    step_ce3();
    step_ce3();
    ena = 1'b0;
    step_ce3();
    checks++;
    if (tx_data !== 48'h0 || tx_strt !== 1'b0 || tx_prbs !== 1'b0) begin
      failures++;
      $display("FAIL ena drop: got data=%h strt=%b prbs=%b, want 0/0/0", tx_data, tx_strt, tx_prbs);
    end
    ena = 1'b1;
    step_ce3();
    checks++;
    if (tx_data !== 48'h0 || tx_strt !== 1'b0) begin
      failures++;
      $display("FAIL re-enable no start: got data=%h strt=%b, want 0/0", tx_data, tx_strt);
    end
    pulse(1'b1, 1'b0);
    expect_start_frames("reburst");
    step_ce3();
    checks++;
    if (tx_data !== Frame0 || tx_prbs !== 1'b1) begin
      failures++;
      $display("FAIL reburst frame0: got %h prbs=%b want %h prbs=1", tx_data, tx_prbs, Frame0);
    end
  endtask

  task automatic test_ce3_start();
    ena = 1'b0;
    step_ce3();
    ena = 1'b1;
    while (!ce3) begin
      @(posedge clk);
      #1;
    end
    pulse(1'b1, 1'b0);
    checks++;
    if (tx_data !== 48'h0 || tx_strt !== 1'b0) begin
      failures++;
      $display("FAIL start on ce3 edge: got data=%h strt=%b, want 0/0", tx_data, tx_strt);
    end
    expect_start_frames("ce3start");
    step_ce3();
    checks++;
    if (tx_data !== Frame0) begin
      failures++;
      $display("FAIL ce3start frame0: got %h want %h", tx_data, Frame0);
    end
  endtask

  task automatic test_coincident();
    pulse(1'b1, 1'b1);
    expect_start_frames("coinc");
    step_ce3();
    checks++;
    if (tx_data !== (Frame0 ^ 48'h1) || inj_cnt !== 8'd2) begin
      failures++;
      $display("FAIL coincident frame0: got %h cnt=%0d want %h cnt=2",
               tx_data, inj_cnt, Frame0 ^ 48'h1);
    end
    step_ce3();
    checks++;
    if (tx_data !== Frame1) begin
      failures++;
      $display("FAIL coincident frame1: got %h want %h", tx_data, Frame1);
    end
  endtask

  task automatic test_async_reset();
    step_ce3();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx_data !== 48'h0 || tx_strt !== 1'b0 || tx_prbs !== 1'b0 || inj_cnt !== 8'h0 ||
        frm_cnt !== 32'h0) begin
      failures++;
      $display("FAIL async reset: got data=%h strt=%b prbs=%b inj=%h frm=%h, want all zero",
               tx_data, tx_strt, tx_prbs, inj_cnt, frm_cnt);
    end
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_inj_saturate();
    pulse(1'b1, 1'b0);
    expect_start_frames("sat");
    step_ce3();
    checks++;
    if (tx_data !== Frame0) begin
      failures++;
      $display("FAIL post-reset frame0: got %h want %h", tx_data, Frame0);
    end
    for (int i = 1; i <= 300; i++) begin
      pulse(1'b0, 1'b1);
      step_ce3();
      if (i == 100) begin
        checks++;
        if (inj_cnt !== 8'd100) begin
          failures++;
          $display("FAIL inj_cnt after 100: got %0d want 100", inj_cnt);
        end
      end
    end
    checks++;
    if (inj_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL inj_cnt saturate: got %h want ff", inj_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_start_burst();
    test_ena_drop();
    test_ce3_start();
    test_coincident();
    test_async_reset();
    test_inj_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
